// File: rtl/seq_divmod_const.sv
// Sequential restoring divider by a compile-time constant.
// Produces floor(dividend / DIVISOR) and dividend mod DIVISOR, one quotient
// bit per cycle (MSB first), behind a start/busy/done handshake. Quotient and
// remainder outputs are only updated on completion, never with partial values.
module seq_divmod_const #(
  parameter int WIDTH   = 6,
  parameter int DIVISOR = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             dividend,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             quotient,
  output logic [$clog2(DIVISOR)-1:0]   remainder
);

  localparam int RW = $clog2(DIVISOR);
  localparam int CW = $clog2(WIDTH + 1);

  // Reject illegal parameterisations at elaboration time.
  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("seq_divmod_const: DIVISOR must be >= 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("seq_divmod_const: WIDTH must be in 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;   // dividend bits still to be consumed, MSB first
  logic [WIDTH-1:0] qs_q;   // quotient bits collected so far
  logic [RW-1:0]    pr_q;   // partial remainder; always < DIVISOR between steps
  logic [CW-1:0]    cnt_q;  // steps completed in the current operation

  logic [RW:0]      pr_sh_d;
  logic             qbit_d;
  logic [RW-1:0]    pr_d;
  logic [WIDTH-1:0] qs_d;
  logic [WIDTH-1:0] sh_d;
  logic             last_d;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    pr_sh_d = {pr_q, sh_q[WIDTH-1]};
    qbit_d  = (pr_sh_d >= (RW+1)'(DIVISOR));
    pr_d    = RW'(qbit_d ? (pr_sh_d - (RW+1)'(DIVISOR)) : pr_sh_d);
    qs_d    = WIDTH'({qs_q, qbit_d});
    sh_d    = sh_q << 1;
    last_d  = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      sh_q      <= '0;
      qs_q      <= '0;
      pr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_q    <= dividend;
            qs_q    <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sh_q  <= sh_d;
          qs_q  <= qs_d;
          pr_q  <= pr_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_d) begin
            quotient  <= qs_d;
            remainder <= pr_d;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divmod_const.sv
// Bench for seq_divmod_const: directed handshake scenarios plus randomized and
// exhaustive operands checked against plain integer division.
module tb_seq_divmod_const;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start1 = 1'b0;
  logic [5:0] dvd1   = '0;
  logic       busy1, done1;
  logic [5:0] q1;
  logic [3:0] r1;

  logic       start2 = 1'b0;
  logic [6:0] dvd2   = '0;
  logic       busy2, done2;
  logic [6:0] q2;
  logic [5:0] r2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divmod_const #(.WIDTH(6), .DIVISOR(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dividend(dvd1),
    .busy(busy1), .done(done1), .quotient(q1), .remainder(r1)
  );

  seq_divmod_const #(.WIDTH(7), .DIVISOR(60)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(dvd2),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full operation on the 6-bit / 10 instance, with the dividend input
  // scrambled while the divider is running.
  task automatic op1(input int d, input string tag);
    int nb;
    bit seen, overlap;
    nb = 0; seen = 0; overlap = 0;
    @(negedge clk); start1 = 1'b1; dvd1 = 6'(d);
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy1 && done1) overlap = 1;
      if (done1) begin seen = 1; break; end
      if (busy1) nb++;
      @(negedge clk);
      dvd1 = 6'($urandom);
    end
    chk({tag, " done"}, 32'(seen), 1);
    chk({tag, " q"}, 32'(q1), 32'(d / 10));
    chk({tag, " r"}, 32'(r1), 32'(d % 10));
    chk({tag, " busy_cycles"}, 32'(nb), 6);
    chk({tag, " busy_done_overlap"}, 32'(overlap), 0);
    @(negedge clk);
    chk({tag, " done_pulse_len"}, 32'(done1), 0);
  endtask

  // Full operation on the 7-bit / 60 instance.
  task automatic op2(input int d);
    bit seen;
    seen = 0;
    @(negedge clk); start2 = 1'b1; dvd2 = 7'(d);
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done2) begin seen = 1; break; end
      @(negedge clk);
    end
    chk($sformatf("w7 %0d done", d), 32'(seen), 1);
    chk($sformatf("w7 %0d q", d), 32'(q2), 32'(d / 60));
    chk($sformatf("w7 %0d r", d), 32'(r2), 32'(d % 60));
  endtask

  initial begin
    int nb, dn, qcap, rcap;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy1), 0);
    chk("rst done", 32'(done1), 0);
    chk("rst q", 32'(q1), 0);
    chk("rst r", 32'(r1), 0);
    chk("rst w7 q", 32'(q2), 0);
    chk("rst w7 r", 32'(r2), 0);
    rst = 1'b0;

    // Basic operation and boundaries
    op1(59, "d59");
    op1(0,  "d0");
    op1(9,  "d9");
    op1(63, "d63");
    op1(10, "d10");

    // start pulsed mid-run with a different dividend must be ignored
    nb = 0; dn = 0; qcap = -1; rcap = -1;
    @(negedge clk); start1 = 1'b1; dvd1 = 6'd45;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy1) nb++;
      if (done1) begin dn++; qcap = int'(q1); rcap = int'(r1); end
      if (i == 2) begin start1 = 1'b1; dvd1 = 6'd20; end
      else start1 = 1'b0;
      @(negedge clk);
    end
    chk("ignore q", 32'(qcap), 4);
    chk("ignore r", 32'(rcap), 5);
    chk("ignore done_count", 32'(dn), 1);
    chk("ignore busy_cycles", 32'(nb), 6);

    // start held in DONE chains the next op with no idle gap
    seen = 0;
    @(negedge clk); start1 = 1'b1; dvd1 = 6'd12;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done1) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("chain1 done", 32'(seen), 1);
    chk("chain1 q", 32'(q1), 1);
    chk("chain1 r", 32'(r1), 2);
    start1 = 1'b1; dvd1 = 6'd37;
    @(negedge clk); start1 = 1'b0; dvd1 = 6'd0;
    chk("chain no_gap busy", 32'(busy1), 1);
    chk("chain no_gap done", 32'(done1), 0);
    nb = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) begin seen = 1; break; end
      if (busy1) nb++;
      @(negedge clk);
    end
    chk("chain2 done", 32'(seen), 1);
    chk("chain2 q", 32'(q1), 3);
    chk("chain2 r", 32'(r1), 7);
    chk("chain2 busy_cycles", 32'(nb), 6);
    @(negedge clk);

    // Reset mid-run aborts at once with no done
    @(negedge clk); start1 = 1'b1; dvd1 = 6'd50;
    @(negedge clk); start1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy1), 0);
    chk("abort done", 32'(done1), 0);
    chk("abort q", 32'(q1), 0);
    chk("abort r", 32'(r1), 0);
    @(negedge clk); rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done1 || busy1) dn++;
      @(negedge clk);
    end
    chk("abort no_activity", 32'(dn), 0);
    op1(50, "after_abort");

    // Randomized operands
    for (int k = 0; k < 20; k++) begin
      op1(int'($urandom_range(0, 63)), $sformatf("rand%0d", k));
    end

    // Exhaustive 7-bit / 60 instance
    for (int d = 0; d < 128; d++) op2(d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
